alu_mc_unit: RTL
================

Name: alu_mc_unit

Overview:
- Parametrised, registered execute-stage ALU: the successor to the single-cycle combinational ALU.
- Takes operands that are already forwarded and muxed upstream; WIDTH is generic.
- Adds a multi-cycle shift-add multiplier with a valid/ready handshake, so the hazard unit can stall on it.
- Owns the architectural {C,N,Z} flag register, including carry override and flag restore from a memory pop (RTI).

Parameters:
- WIDTH, 16, operand/result width (>=4).
- SHAMT_W, $clog2(WIDTH)+1, shift-amount bits taken from op_b.
- FLAG_W, 3, flag vector width {C,N,Z}; fixed, not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept; low while multiplying.
- alu_op  in  4  opcode (see package).
- op_a  in  WIDTH  first operand.
- op_b  in  WIDTH  second operand / shift amount.
- carry_sel  in  2  00 ALU carry, 01 set C, 10 clear C, 11 keep C.
- flag_we  in  1  the op updates flags.
- flush  in  1  abort in-flight op, drop current input.
- flag_restore  in  1  load flags from flags_pop.
- flags_pop  in  FLAG_W  popped {C,N,Z}.
- out_valid  out  1  result valid, one-cycle pulse.
- result  out  WIDTH  registered result.
- flags  out  FLAG_W  registered {C,N,Z}.

Behaviour:
- Reset (sync, active-high): result=0, out_valid=0, flags=000, state=IDLE, in_ready=1. Reset mid-multiply discards the operation; no out_valid.
- Accept: in_valid && in_ready && !flush.
- Single-cycle ops: result, out_valid=1 and flags are registered at the accept edge (latency 1).
- Ops and carry rules:
  - NOT: C=0.
  - INC, DEC, ADD, SUB: (WIDTH+1)-bit arithmetic; C = bit WIDTH (borrow for SUB/DEC).
  - AND, OR: C=0.
  - SHL by s = op_b[SHAMT_W-1:0]: s=0 gives result=op_a, C=0; 1<=s<=WIDTH gives C=op_a[WIDTH-s]; s>WIDTH gives result=0, C=0.
  - SHR: C=op_a[s-1] for 1<=s<=WIDTH; 0 otherwise.
  - MUL: product low WIDTH bits; C = |high half.
  - PASS (any other code): result=op_b, C=0.
- Flags: N=result[WIDTH-1], Z=(result==0), C per carry_sel. Flags update only when flag_we is set at accept; carry_sel=11 holds the old C.
- FSM:
  - IDLE: accepting MUL latches the operands, loads count=WIDTH and goes to MUL, with in_ready=0 from the next cycle.
  - MUL: one shift-add per cycle. When count reaches 0, write result, out_valid=1, apply flags (flag_we latched at accept), return to IDLE. Total latency WIDTH+1 cycles from the accept edge.
  - flush in MUL: return to IDLE next edge; no out_valid, flags unchanged.
  - flush in IDLE: in_valid is ignored that cycle.
- out_valid is 0 in every cycle without a completion.
- flag_restore: flags<=flags_pop at the next edge, in either state. It has priority over any same-cycle ALU flag update; result/out_valid still update.
- flush and flag_restore in the same cycle: the restore still happens.

Decomposition:
- Package alu_pkg:
  - alu_op_e: NOT=0, INC=1, DEC=2, ADD=3, SUB=4, AND=5, OR=6, SHL=7, SHR=8, MUL=9; 10-15 = PASS.
  - carry_sel_e.
  - flag index constants: C=2, N=1, Z=0.
  - alu_state_e {IDLE, MUL}.
- Sub-module seq_multiplier (start/done, WIDTH generic, shift-add, 2*WIDTH product) holds the counter and accumulator; the top holds the FSM, the combinational datapath and the flag register.

Test Plan:
1. rst=1 for 2 cycles, then ADD 0xFFFF+0x0001, flag_we=1, carry_sel=00 -> next cycle result=0x0000, out_valid=1, flags=101 (C=1, N=0, Z=1).
2. SUB 0x0003-0x0005, carry_sel=11 with prior C=0 -> result=0xFFFE, flags=010; then SHR 0x8001 by 1, carry_sel=00 -> result=0x4000, flags=100.
3. MUL 0x0100*0x0101 (WIDTH=16) -> in_ready=0 for 16 cycles; out_valid at cycle 17; result=0x0100, flags=100; no second pulse.
4. MUL 7*9 with flush asserted on cycle 5 -> no out_valid, flags unchanged, in_ready=1 on cycle 6; a following ADD 1+1 -> result=0x0002.
5. ADD with flag_we=1 and flag_restore=1, flags_pop=011, same cycle -> flags=011, result still updated, out_valid=1.
6. SHL 0x0001 by 16 -> result=0x0000, C=1, Z=1; SHL by 17 -> C=0; opcode 0xF with op_b=0x1234 -> result=0x1234.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the execute-stage ALU.
//   alu_op_e     - opcode map; codes 10..15 behave as PASS (result = op_b)
//   carry_sel_e  - carry override select for the C flag
//   FLAG_*       - bit positions inside the {C,N,Z} flag vector
//   alu_state_e  - top-level sequencing state
package alu_pkg;

  localparam int FLAG_W = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [3:0] {
    OP_NOT = 4'd0,
    OP_INC = 4'd1,
    OP_DEC = 4'd2,
    OP_ADD = 4'd3,
    OP_SUB = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_MUL = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    CS_ALU  = 2'b00,
    CS_SET  = 2'b01,
    CS_CLR  = 2'b10,
    CS_KEEP = 2'b11
  } carry_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  // Final C flag after applying the carry override.
  function automatic logic resolve_carry(input logic [1:0] csel, input logic alu_c,
                                         input logic old_c);
    logic c;
    case (csel)
      CS_ALU:  c = alu_c;
      CS_SET:  c = 1'b1;
      CS_CLR:  c = 1'b0;
      default: c = old_c;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_mc_unit_seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one partial product per cycle.
//   clk, rst  - clock, synchronous active-high reset (control only)
//   start     - load operands and begin (ignored while busy by construction upstream)
//   abort     - drop the operation in flight
//   a, b      - multiplicand, multiplier
//   done      - combinational: the current cycle performs the last shift-add
//   product   - 2*WIDTH product; valid in the cycle done is high
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  import alu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic               busy;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] mcand_p0;
  logic [2*WIDTH-1:0] acc_p0;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier_p0;

  // The final partial product is presented directly on product so the
  // caller can register it on the same edge that retires the count.
  assign acc_next = mplier_p0[0] ? (acc_p0 + mcand_p0) : acc_p0;
  assign done     = busy && (count == CNT_W'(1));
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (abort) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= CNT_W'(WIDTH);
    end else if (busy) begin
      count <= count - CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

  // ---- stage p0: operand / accumulator registers ----
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_p0  <= {{WIDTH{1'b0}}, a};
      mplier_p0 <= b;
      acc_p0    <= '0;
    end else if (busy) begin
      acc_p0    <= acc_next;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

endmodule

// File: rtl/alu_mc_unit.sv
// alu_mc_unit: registered execute-stage ALU with a multi-cycle multiplier
// and the architectural {C,N,Z} flag register.
//   clk, rst      - clock, synchronous active-high reset
//   in_valid      - operation presented;  in_ready - low while multiplying
//   alu_op        - opcode (alu_op_e), op_a / op_b operands (op_b = shift amount)
//   carry_sel     - C override (ALU / set / clear / keep)
//   flag_we       - operation updates the flags
//   flush         - abort multiply in flight, drop the current input
//   flag_restore  - load flags from flags_pop (wins over ALU flag updates)
//   out_valid     - one-cycle completion pulse, result - registered result
//   flags         - registered {C,N,Z}
module alu_mc_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [1:0]        carry_sel,
  input  logic              flag_we,
  input  logic              flush,
  input  logic              flag_restore,
  input  logic [FLAG_W-1:0] flags_pop,
  output logic              out_valid,
  output logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags
);

  alu_state_e         state;
  logic               accept;
  logic               is_mul;
  logic               mul_start;
  logic               mul_abort;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     alu_out;
  logic               mul_flag_we_p0;
  logic [1:0]         mul_csel_p0;

  // {carry, result}. Shifts are done one bit wider so the bit shifted out
  // lands in the carry position; amounts beyond WIDTH shift everything out.
  function automatic logic [WIDTH:0] alu_compute(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH:0]     wide;
    logic [WIDTH:0]     shr_t;
    logic [SHAMT_W-1:0] s;
    s     = b[SHAMT_W-1:0];
    shr_t = {a, 1'b0} >> s;
    case (op)
      OP_NOT:  wide = {1'b0, ~a};
      OP_INC:  wide = {1'b0, a} + (WIDTH+1)'(1);
      OP_DEC:  wide = {1'b0, a} - (WIDTH+1)'(1);
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_SHL:  wide = {1'b0, a} << s;
      OP_SHR:  wide = {shr_t[0], shr_t[WIDTH:1]};
      default: wide = {1'b0, b};
    endcase
    return wide;
  endfunction

  function automatic logic [FLAG_W-1:0] next_flags(input logic [WIDTH-1:0] res,
                                                   input logic c,
                                                   input logic [1:0] csel,
                                                   input logic old_c);
    logic [FLAG_W-1:0] f;
    f[FLAG_C] = resolve_carry(csel, c, old_c);
    f[FLAG_N] = res[WIDTH-1];
    f[FLAG_Z] = (res == '0);
    return f;
  endfunction

  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign is_mul    = (alu_op == OP_MUL);
  assign mul_start = accept && is_mul;
  assign mul_abort = flush && (state == ST_MUL);
  assign alu_out   = alu_compute(alu_op, op_a, op_b);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // ---- stage p1: result, completion pulse, flag register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      result         <= '0;
      out_valid      <= 1'b0;
      flags          <= '0;
      mul_flag_we_p0 <= 1'b0;
      mul_csel_p0    <= CS_ALU;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state          <= ST_MUL;
              mul_flag_we_p0 <= flag_we;
              mul_csel_p0    <= carry_sel;
            end else begin
              result    <= alu_out[WIDTH-1:0];
              out_valid <= 1'b1;
              if (flag_we)
                flags <= next_flags(alu_out[WIDTH-1:0], alu_out[WIDTH], carry_sel,
                                    flags[FLAG_C]);
            end
          end
        end
        ST_MUL: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (mul_done) begin
            state     <= ST_IDLE;
            result    <= mul_product[WIDTH-1:0];
            out_valid <= 1'b1;
            if (mul_flag_we_p0)
              flags <= next_flags(mul_product[WIDTH-1:0], |mul_product[2*WIDTH-1:WIDTH],
                                  mul_csel_p0, flags[FLAG_C]);
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Restore overrides any flag update above, regardless of flush.
      if (flag_restore) flags <= flags_pop;
    end
  end

endmodule
